// File: rtl/n64_vdemux_gen_pkg.sv
// Shared definitions for the N64 video demux: phase encodings and field widths.
package n64_vdemux_gen_pkg;

    localparam int COLOR_W_DEF = 7;
    localparam int SYNC_W      = 4;

    typedef enum logic [2:0] {
        PH_IDLE = 3'd0,
        PH_SY   = 3'd1,
        PH_R    = 3'd2,
        PH_G    = 3'd3,
        PH_B    = 3'd4
    } phase_e;

    // A new sync nibble arriving while still in R or G means the group was cut short.
    function automatic logic cut_short(input phase_e p);
        return (p == PH_R) || (p == PH_G);
    endfunction

endpackage

// File: rtl/n64_vdemux_gen_gamma_seq.sv
// Gamma ROM sequencer: walks R/G/B of the stage-1 pixel through the shared ROM port and
// files each result into a per-group bank, so a slow ROM never overwrites a pixel still owed to the output.
module n64_vdemux_gen_gamma_seq
    import n64_vdemux_gen_pkg::*;
#(
    parameter int COLOR_W = COLOR_W_DEF,
    parameter int PAGE_W  = 2,
    parameter int ROM_LAT = 1
) (
    input  logic                         nCLK,
    input  logic                         RST,
    input  phase_e                       ph,
    input  logic                         bank_q,
    input  logic [2:0][COLOR_W-1:0]      src_rgb,
    input  logic [PAGE_W-1:0]            page,
    input  logic [COLOR_W-1:0]           rom_q,
    output logic [PAGE_W+COLOR_W-1:0]    rom_addr,
    output logic [2:0][COLOR_W-1:0]      gam_rgb
);

    logic       iss_vld;
    logic [1:0] iss_ch;
    logic       iss_bank;

    logic [ROM_LAT:0]       tag_vld;
    logic [ROM_LAT:0]       tag_bank;
    logic [ROM_LAT:0][1:0]  tag_ch;
    logic [1:0][2:0][COLOR_W-1:0] bank_rgb;

    // Address is registered one cycle ahead, so the SY cycle issues R into the bank the
    // group toggle is about to select.
    always_comb begin
        iss_vld  = 1'b1;
        iss_ch   = 2'd2;
        iss_bank = bank_q;
        case (ph)
            PH_SY: iss_bank = ~bank_q;
            PH_R:  iss_ch   = 2'd1;
            PH_G:  iss_ch   = 2'd0;
            default: iss_vld = 1'b0;
        endcase
    end

    always_ff @(negedge nCLK or posedge RST) begin
        if (RST) begin
            rom_addr <= '0;
            tag_vld  <= '0;
            tag_bank <= '0;
            tag_ch   <= '0;
            bank_rgb <= '0;
        end else begin
            tag_vld  <= {tag_vld[ROM_LAT-1:0], iss_vld};
            tag_bank <= {tag_bank[ROM_LAT-1:0], iss_bank};
            tag_ch   <= {tag_ch[ROM_LAT-1:0], iss_ch};
            if (iss_vld)
                rom_addr <= {page, src_rgb[iss_ch]};
            if (tag_vld[ROM_LAT])
                bank_rgb[tag_bank[ROM_LAT]][tag_ch[ROM_LAT]] <= rom_q;
        end
    end

    assign gam_rgb = bank_rgb[~bank_q];

endmodule

// File: rtl/n64_vdemux_gen.sv
// N64 video demux: phase FSM, capture/deblur stages, gamma-matched delay line and output mux.
// Every group leaves the output exactly three SY cycles after its own SY, gamma or not.
module n64_vdemux_gen
    import n64_vdemux_gen_pkg::*;
#(
    parameter int COLOR_W = COLOR_W_DEF,
    parameter int PAGE_W  = 2,
    parameter int ROM_LAT = 1
) (
    input  logic                          nCLK,
    input  logic                          RST,
    input  logic                          nDSYNC,
    input  logic [COLOR_W-1:0]            D_i,
    input  logic                          ndo_deblur_i,
    input  logic                          nblank_rgb_i,
    input  logic                          n15bit_mode_i,
    input  logic                          gamma_en_i,
    input  logic [PAGE_W-1:0]             gamma_page_i,
    output logic [PAGE_W+COLOR_W-1:0]     rom_addr_o,
    output logic                          rom_rden_o,
    input  logic [COLOR_W-1:0]            rom_q_i,
    output logic [SYNC_W+3*COLOR_W-1:0]   vdata_o,
    output logic                          vdata_valid_o,
    output logic                          sync_err_o
);

    localparam logic [COLOR_W-1:0] LSB_MASK = (COLOR_W'(1) << (COLOR_W - 5)) - COLOR_W'(1);

    phase_e phase_q, ph;
    logic   err_d;

    logic                     full_q;
    logic [COLOR_W-1:0]       d_cap;
    logic [SYNC_W-1:0]        s0_sync, s1_sync, s2_sync;
    logic [2:0][COLOR_W-1:0]  s0_rgb, s1_rgb, s2_rgb;
    logic [2:0][COLOR_W-1:0]  addr_rgb, gam_rgb;
    logic [2:0]               vld_pipe;
    logic                     bank_q;
    logic                     xfer_rgb;

    always_comb begin
        ph    = phase_q;
        err_d = 1'b0;
        if (!nDSYNC) begin
            ph    = PH_SY;
            err_d = cut_short(phase_q);
        end else begin
            case (phase_q)
                PH_SY:   ph = PH_R;
                PH_R:    ph = PH_G;
                PH_G:    ph = PH_B;
                default: ph = phase_q;   // IDLE waits for sync, B saturates
            endcase
        end
    end

    assign d_cap      = full_q ? D_i : (D_i & ~LSB_MASK);
    assign xfer_rgb   = ndo_deblur_i || nblank_rgb_i;
    assign addr_rgb   = (ph == PH_SY && xfer_rgb) ? s0_rgb : s1_rgb;
    assign rom_rden_o = gamma_en_i;

    always_ff @(negedge nCLK or posedge RST) begin
        if (RST) begin
            phase_q       <= PH_IDLE;
            full_q        <= 1'b1;
            s0_sync       <= '0;
            s1_sync       <= '0;
            s2_sync       <= '0;
            s0_rgb        <= '0;
            s1_rgb        <= '0;
            s2_rgb        <= '0;
            vld_pipe      <= '0;
            bank_q        <= 1'b0;
            vdata_o       <= '0;
            vdata_valid_o <= 1'b0;
            sync_err_o    <= 1'b0;
        end else begin
            phase_q       <= ph;
            sync_err_o    <= err_d;
            vdata_valid_o <= 1'b0;
            case (ph)
                PH_SY: begin
                    s0_sync <= D_i[SYNC_W-1:0];
                    // Width mode only switches on the falling edge of nVS.
                    if (s0_sync[3] && !D_i[3])
                        full_q <= n15bit_mode_i;
                    s1_sync <= s0_sync;
                    if (xfer_rgb)
                        s1_rgb <= s0_rgb;
                    s2_sync  <= s1_sync;
                    s2_rgb   <= s1_rgb;
                    vld_pipe <= {vld_pipe[1:0], 1'b1};
                    bank_q   <= ~bank_q;
                    if (vld_pipe[2]) begin
                        vdata_o       <= {s2_sync, gamma_en_i ? gam_rgb : s2_rgb};
                        vdata_valid_o <= 1'b1;
                    end
                end
                PH_R: s0_rgb[2] <= d_cap;
                PH_G: s0_rgb[1] <= d_cap;
                PH_B: if (phase_q == PH_G) s0_rgb[0] <= d_cap;
                default: ;
            endcase
        end
    end

    n64_vdemux_gen_gamma_seq #(
        .COLOR_W (COLOR_W),
        .PAGE_W  (PAGE_W),
        .ROM_LAT (ROM_LAT)
    ) u_gamma (
        .nCLK     (nCLK),
        .RST      (RST),
        .ph       (ph),
        .bank_q   (bank_q),
        .src_rgb  (addr_rgb),
        .page     (gamma_page_i),
        .rom_q    (rom_q_i),
        .rom_addr (rom_addr_o),
        .gam_rgb  (gam_rgb)
    );

endmodule

// File: tb/tb_n64_vdemux_gen.sv
// Directed bench: two demux instances (ROM latency 1 and 3) fed the same video stream,
// each with an inverting ROM model; expected outputs are hand-computed per group.
module tb_n64_vdemux_gen;

    localparam int CW = 7;
    localparam int PW = 2;
    localparam int VW = 4 + 3*CW;

    logic          nCLK = 1'b0;
    logic          RST = 1'b1;
    logic          nDSYNC = 1'b1;
    logic [CW-1:0] D_i = '0;
    logic          ndo = 1'b1, nblank = 1'b1, n15 = 1'b1, gen = 1'b0;
    logic [PW-1:0] page = '0;

    logic [PW+CW-1:0] addr1, addr3;
    logic             rden1, rden3;
    logic [CW-1:0]    q1 = '0;
    logic [2:0][CW-1:0] q3p = '0;
    logic [VW-1:0]    vd1, vd3;
    logic             vv1, vv3, er1, er3;

    int n_chk = 0;
    int n_pass = 0;

    always #5 nCLK = ~nCLK;

    // ROM contents: q = ~colour bits of the address, delivered ROM_LAT cycles later.
    always @(negedge nCLK) begin
        q1  <= ~addr1[CW-1:0];
        q3p <= {q3p[1:0], ~addr3[CW-1:0]};
    end

    n64_vdemux_gen #(.COLOR_W(CW), .PAGE_W(PW), .ROM_LAT(1)) dut1 (
        .nCLK(nCLK), .RST(RST), .nDSYNC(nDSYNC), .D_i(D_i),
        .ndo_deblur_i(ndo), .nblank_rgb_i(nblank), .n15bit_mode_i(n15),
        .gamma_en_i(gen), .gamma_page_i(page),
        .rom_addr_o(addr1), .rom_rden_o(rden1), .rom_q_i(q1),
        .vdata_o(vd1), .vdata_valid_o(vv1), .sync_err_o(er1)
    );

    n64_vdemux_gen #(.COLOR_W(CW), .PAGE_W(PW), .ROM_LAT(3)) dut3 (
        .nCLK(nCLK), .RST(RST), .nDSYNC(nDSYNC), .D_i(D_i),
        .ndo_deblur_i(ndo), .nblank_rgb_i(nblank), .n15bit_mode_i(n15),
        .gamma_en_i(gen), .gamma_page_i(page),
        .rom_addr_o(addr3), .rom_rden_o(rden3), .rom_q_i(q3p[2]),
        .vdata_o(vd3), .vdata_valid_o(vv3), .sync_err_o(er3)
    );

    typedef struct {
        logic [3:0]    s;
        logic [CW-1:0] r, g, b;
        logic          short_g;
        logic          ev;
        logic [VW-1:0] ex;
        logic          eerr;
    } grp_t;

    grp_t tbl [23];

    function automatic logic [VW-1:0] vd(input logic [3:0] s, input logic [CW-1:0] r,
                                         input logic [CW-1:0] g, input logic [CW-1:0] b);
        return {s, r, g, b};
    endfunction

    function automatic grp_t mkg(input logic [3:0] s, input logic [CW-1:0] r, input logic [CW-1:0] g,
                                 input logic [CW-1:0] b, input logic sh, input logic ev,
                                 input logic [VW-1:0] ex, input logic eerr);
        grp_t t;
        t.s = s; t.r = r; t.g = g; t.b = b;
        t.short_g = sh; t.ev = ev; t.ex = ex; t.eerr = eerr;
        return t;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    task automatic tick(input logic nd, input logic [CW-1:0] d);
        nDSYNC = nd;
        D_i    = d;
        @(negedge nCLK);
        #1;
    endtask

    initial begin
        tbl[0]  = mkg(4'hF, 7'h55, 7'h2A, 7'h7F, 0, 0, '0, 0);
        tbl[1]  = mkg(4'hF, 7'h55, 7'h2A, 7'h7F, 0, 0, '0, 0);
        tbl[2]  = mkg(4'hF, 7'h55, 7'h2A, 7'h7F, 0, 0, '0, 0);
        tbl[3]  = mkg(4'hF, 7'h55, 7'h2A, 7'h7F, 0, 1, vd(4'hF, 7'h55, 7'h2A, 7'h7F), 0);
        tbl[4]  = mkg(4'hF, 7'h55, 7'h2A, 7'h7F, 0, 1, vd(4'hF, 7'h55, 7'h2A, 7'h7F), 0);
        tbl[5]  = mkg(4'h7, 7'h55, 7'h2A, 7'h7F, 0, 1, vd(4'hF, 7'h55, 7'h2A, 7'h7F), 0);
        tbl[6]  = mkg(4'hF, 7'h55, 7'h2A, 7'h7F, 0, 1, vd(4'hF, 7'h55, 7'h2A, 7'h7F), 0);
        tbl[7]  = mkg(4'h7, 7'h55, 7'h2A, 7'h7F, 0, 1, vd(4'hF, 7'h55, 7'h2A, 7'h7F), 0);
        tbl[8]  = mkg(4'hF, 7'h11, 7'h22, 7'h33, 0, 1, vd(4'h7, 7'h54, 7'h28, 7'h7C), 0);
        tbl[9]  = mkg(4'hE, 7'h44, 7'h55, 7'h66, 0, 1, vd(4'hF, 7'h54, 7'h28, 7'h7C), 0);
        tbl[10] = mkg(4'hF, 7'h01, 7'h02, 7'h03, 0, 1, vd(4'h7, 7'h55, 7'h2A, 7'h7F), 0);
        tbl[11] = mkg(4'hF, 7'h55, 7'h2A, 7'h7F, 0, 1, vd(4'hF, 7'h11, 7'h22, 7'h33), 0);
        tbl[12] = mkg(4'hF, 7'h55, 7'h2A, 7'h7F, 0, 1, vd(4'hE, 7'h11, 7'h22, 7'h33), 0);
        tbl[13] = mkg(4'hF, 7'h11, 7'h22, 7'h33, 0, 1, vd(4'hF, 7'h01, 7'h02, 7'h03), 0);
        tbl[14] = mkg(4'hF, 7'h55, 7'h2A, 7'h7F, 0, 1, vd(4'hF, 7'h2A, 7'h55, 7'h00), 0);
        tbl[15] = mkg(4'hF, 7'h55, 7'h2A, 7'h7F, 0, 1, vd(4'hF, 7'h2A, 7'h55, 7'h00), 0);
        tbl[16] = mkg(4'hF, 7'h55, 7'h2A, 7'h7F, 0, 1, vd(4'hF, 7'h6E, 7'h5D, 7'h4C), 0);
        tbl[17] = mkg(4'hF, 7'h11, 7'h22, 7'h33, 0, 1, vd(4'hF, 7'h55, 7'h2A, 7'h7F), 0);
        tbl[18] = mkg(4'hE, 7'h44, 7'h55, 7'h66, 1, 1, vd(4'hF, 7'h55, 7'h2A, 7'h7F), 0);
        tbl[19] = mkg(4'hF, 7'h01, 7'h02, 7'h03, 0, 1, vd(4'hF, 7'h55, 7'h2A, 7'h7F), 1);
        tbl[20] = mkg(4'hF, 7'h55, 7'h2A, 7'h7F, 0, 1, vd(4'hF, 7'h11, 7'h22, 7'h33), 0);
        tbl[21] = mkg(4'hF, 7'h55, 7'h2A, 7'h7F, 0, 1, vd(4'hE, 7'h44, 7'h55, 7'h33), 0);
        tbl[22] = mkg(4'hF, 7'h55, 7'h2A, 7'h7F, 0, 1, vd(4'hF, 7'h01, 7'h02, 7'h03), 0);

        repeat (2) @(negedge nCLK);
        #1;
        chk("reset vdata L1", vd1, '0);
        chk("reset valid L1", vv1, 0);
        chk("reset err L1",   er1, 0);
        chk("reset addr L1",  addr1, '0);
        chk("reset vdata L3", vd3, '0);
        RST = 1'b0;

        for (int i = 0; i < 23; i++) begin
            if (i == 3) n15 = 1'b0;
            if (i == 6) n15 = 1'b1;
            if (i == 10) begin ndo = 1'b0; nblank = 1'b0; end
            tick(1'b0, {3'b000, tbl[i].s});
            if (i == 10) begin ndo = 1'b1; nblank = 1'b1; end
            chk($sformatf("g%0d valid L1", i), vv1, tbl[i].ev);
            chk($sformatf("g%0d valid L3", i), vv3, tbl[i].ev);
            if (tbl[i].ev) begin
                chk($sformatf("g%0d vdata L1", i), vd1, tbl[i].ex);
                chk($sformatf("g%0d vdata L3", i), vd3, tbl[i].ex);
            end
            chk($sformatf("g%0d err L1", i), er1, tbl[i].eerr);
            chk($sformatf("g%0d err L3", i), er3, tbl[i].eerr);
            if (i == 13) begin gen = 1'b1; page = 2'd2; end
            if (i == 14) begin
                chk("rom addr page L1", addr1, 9'h111);
                chk("rom addr page L3", addr3, 9'h111);
                chk("rom rden", rden1, 1);
            end
            if (i == 16) gen = 1'b0;
            tick(1'b1, tbl[i].r);
            chk($sformatf("g%0d strobe drop L1", i), vv1, 0);
            chk($sformatf("g%0d err drop L1", i), er1, 0);
            chk($sformatf("g%0d strobe drop L3", i), vv3, 0);
            tick(1'b1, tbl[i].g);
            if (!tbl[i].short_g) tick(1'b1, tbl[i].b);
        end

        // Reset pulse in the middle of a B cycle.
        tick(1'b0, 7'h05);
        chk("pre-reset vdata L1", vd1, vd(4'hF, 7'h55, 7'h2A, 7'h7F));
        tick(1'b1, 7'h12);
        tick(1'b1, 7'h34);
        nDSYNC = 1'b1;
        D_i    = 7'h56;
        #2 RST = 1'b1;
        #1;
        chk("async rst vdata L1", vd1, '0);
        chk("async rst vdata L3", vd3, '0);
        chk("async rst addr L1",  addr1, '0);
        chk("async rst valid L1", vv1, 0);
        #1 RST = 1'b0;
        @(negedge nCLK);
        #1;

        for (int h = 0; h < 4; h++) begin
            tick(1'b0, 7'h0A);
            chk($sformatf("post-rst h%0d valid L1", h), vv1, (h == 3));
            chk($sformatf("post-rst h%0d valid L3", h), vv3, (h == 3));
            chk($sformatf("post-rst h%0d vdata L1", h), vd1,
                (h == 3) ? vd(4'hA, 7'h12, 7'h34, 7'h56) : '0);
            tick(1'b1, 7'h12);
            tick(1'b1, 7'h34);
            tick(1'b1, 7'h56);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
